// File: rtl/arm_mmio_timer_pkg.sv
// Shared constants for the memory-mapped down-counting timer: register
// byte offsets inside the 32-byte window and CTRL bit positions.
package arm_mmio_timer_pkg;

    // Size of the responder window in bytes and the address bit where it starts
    localparam int unsigned WINDOW_BYTES = 32;
    localparam int unsigned WINDOW_LSB   = $clog2(WINDOW_BYTES);

    // Register byte offsets (bits [1:0] of the bus address are ignored)
    localparam logic [4:0] CTRL_OFF     = 5'h00;
    localparam logic [4:0] LOAD_OFF     = 5'h04;
    localparam logic [4:0] COUNT_OFF    = 5'h08;
    localparam logic [4:0] STATUS_OFF   = 5'h0C;
    localparam logic [4:0] PRESCALE_OFF = 5'h10;

    // CTRL register bit positions
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_AUTO_BIT   = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;

    // STATUS register bit positions
    localparam int unsigned STATUS_EXPIRED_BIT = 0;

    // Prescaler counter width
    localparam int unsigned PRESCALE_W = 16;

endpackage

// File: rtl/arm_timer_prescaler.sv
// Prescaler for the MMIO timer: counts enabled cycles and emits a one-cycle
// tick every PRESCALE+1 enabled cycles. A clear restarts the phase at 0.
module arm_timer_prescaler
    import arm_mmio_timer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    // Tick fires in the cycle where the phase counter reaches the prescale value
    assign tick_o = enable_i && (pcnt_q == prescale_i);

    // Next phase: clear wins, otherwise wrap on tick or advance while enabled
    always_comb begin
        pcnt_d = pcnt_q;
        if (clear_i) begin
            pcnt_d = {PRESCALE_W{1'b0}};
        end else if (enable_i) begin
            if (tick_o) begin
                pcnt_d = {PRESCALE_W{1'b0}};
            end else begin
                pcnt_d = pcnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // Phase counter register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pcnt_q <= {PRESCALE_W{1'b0}};
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/arm_mmio_timer.sv
// Memory-mapped down-counting timer responding on the CPU's single-master
// bus. Combinational reads, writes commit on the rising edge, level IRQ on
// expiry gated by IRQ_EN.
module arm_mmio_timer
    import arm_mmio_timer_pkg::*;
#(
    parameter int unsigned          BusWidth = 32,
    parameter logic [BusWidth-1:0]  BaseAddr = 32'hFFFF_0000
) (
    input  logic                i_CLK,
    input  logic                i_NRESET,
    input  logic                i_MemWrite,
    input  logic [BusWidth-1:0] i_Address,
    input  logic [BusWidth-1:0] i_WriteData,
    output logic [BusWidth-1:0] o_ReadData,
    output logic                o_Select,
    output logic                o_IRQ
);

    // Register state
    logic                  en_q,       en_d;
    logic                  auto_q,     auto_d;
    logic                  irq_en_q,   irq_en_d;
    logic [BusWidth-1:0]   load_q,     load_d;
    logic [BusWidth-1:0]   count_q,    count_d;
    logic                  expired_q,  expired_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  irq_q,      irq_d;

    // Decode and event signals
    logic                  hit_s;
    logic [4:0]            offset_s;
    logic                  wr_s;
    logic                  wr_ctrl_s;
    logic                  wr_load_s;
    logic                  wr_count_s;
    logic                  wr_status_s;
    logic                  wr_prescale_s;
    logic                  tick_s;
    logic                  zero_s;
    logic                  expire_s;
    logic [BusWidth-1:0]   rdata_s;
    logic                  unused_addr_s;

    // Byte-lane bits of the address carry no meaning for word registers
    assign unused_addr_s = ^i_Address[1:0];

    assign hit_s    = (i_Address[BusWidth-1:WINDOW_LSB] == BaseAddr[BusWidth-1:WINDOW_LSB]);
    assign offset_s = {i_Address[4:2], 2'b00};
    assign o_Select = hit_s;

    assign wr_s          = i_MemWrite & hit_s;
    assign wr_ctrl_s     = wr_s && (offset_s == CTRL_OFF);
    assign wr_load_s     = wr_s && (offset_s == LOAD_OFF);
    assign wr_count_s    = wr_s && (offset_s == COUNT_OFF);
    assign wr_status_s   = wr_s && (offset_s == STATUS_OFF);
    assign wr_prescale_s = wr_s && (offset_s == PRESCALE_OFF);

    // Any CTRL or PRESCALE write restarts the prescaler phase
    arm_timer_prescaler u_prescaler (
        .clk_i      (i_CLK),
        .rst_n_i    (i_NRESET),
        .enable_i   (en_q),
        .clear_i    (wr_ctrl_s | wr_prescale_s),
        .prescale_i (prescale_q),
        .tick_o     (tick_s)
    );

    assign zero_s   = (count_q == {BusWidth{1'b0}});
    assign expire_s = tick_s & zero_s;

    // Next-state for all registers; bus writes take priority over tick effects,
    // except that an expiry set beats a same-cycle write-1-clear of EXPIRED
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        load_d     = load_q;
        count_d    = count_q;
        expired_d  = expired_q;
        prescale_d = prescale_q;

        if (wr_ctrl_s) begin
            en_d     = i_WriteData[CTRL_EN_BIT];
            auto_d   = i_WriteData[CTRL_AUTO_BIT];
            irq_en_d = i_WriteData[CTRL_IRQ_EN_BIT];
        end else if (expire_s && !auto_q) begin
            en_d = 1'b0;
        end else begin
            en_d = en_q;
        end

        if (wr_load_s) begin
            load_d = i_WriteData;
        end else begin
            load_d = load_q;
        end

        if (wr_prescale_s) begin
            prescale_d = i_WriteData[PRESCALE_W-1:0];
        end else begin
            prescale_d = prescale_q;
        end

        if (wr_count_s) begin
            count_d = i_WriteData;
        end else if (tick_s) begin
            if (!zero_s) begin
                count_d = count_q - {{(BusWidth-1){1'b0}}, 1'b1};
            end else if (auto_q) begin
                count_d = load_q;
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end

        if (expire_s) begin
            expired_d = 1'b1;
        end else if (wr_status_s && i_WriteData[STATUS_EXPIRED_BIT]) begin
            expired_d = 1'b0;
        end else begin
            expired_d = expired_q;
        end
    end

    // Interrupt is registered from next-state so it tracks EXPIRED & IRQ_EN exactly
    assign irq_d = expired_d & irq_en_d;

    // Register file, cleared asynchronously by reset
    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            load_q     <= {BusWidth{1'b0}};
            count_q    <= {BusWidth{1'b0}};
            expired_q  <= 1'b0;
            prescale_q <= {PRESCALE_W{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            prescale_q <= prescale_d;
            irq_q      <= irq_d;
        end
    end

    // Combinational read mux; unmapped offsets and misses return zero
    always_comb begin
        rdata_s = {BusWidth{1'b0}};
        if (hit_s) begin
            case (offset_s)
                CTRL_OFF: begin
                    rdata_s[CTRL_EN_BIT]     = en_q;
                    rdata_s[CTRL_AUTO_BIT]   = auto_q;
                    rdata_s[CTRL_IRQ_EN_BIT] = irq_en_q;
                end
                LOAD_OFF:     rdata_s = load_q;
                COUNT_OFF:    rdata_s = count_q;
                STATUS_OFF:   rdata_s[STATUS_EXPIRED_BIT] = expired_q;
                PRESCALE_OFF: rdata_s[PRESCALE_W-1:0] = prescale_q;
                default:      rdata_s = {BusWidth{1'b0}};
            endcase
        end else begin
            rdata_s = {BusWidth{1'b0}};
        end
    end

    assign o_ReadData = rdata_s;
    assign o_IRQ      = irq_q;

endmodule

// File: tb/tb_arm_mmio_timer.sv
// Self-checking bench for arm_mmio_timer: a reset/decode vector table,
// hand-written multi-cycle sequences, and randomized traffic compared
// against a cycle-level behavioural model of the register rules.
module tb_arm_mmio_timer;

    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_LOAD = BASE + 32'h04;
    localparam logic [31:0] A_CNT  = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C;
    localparam logic [31:0] A_PRE  = BASE + 32'h10;

    logic        clk;
    logic        nreset;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        select;
    logic        irq;

    int errors = 0;
    int checks = 0;

    arm_mmio_timer dut (
        .i_CLK       (clk),
        .i_NRESET    (nreset),
        .i_MemWrite  (mem_write),
        .i_Address   (address),
        .i_WriteData (write_data),
        .o_ReadData  (read_data),
        .o_Select    (select),
        .o_IRQ       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_en, m_auto, m_irqen, m_exp;
    logic [31:0] m_load, m_count;
    int unsigned m_pre;
    int unsigned m_phase;   // enabled cycles since the prescaler was last restarted

    function automatic void model_reset();
        m_en = 0; m_auto = 0; m_irqen = 0; m_exp = 0;
        m_load = 32'd0; m_count = 32'd0; m_pre = 0; m_phase = 0;
    endfunction

    function automatic bit in_window(logic [31:0] a);
        return (a & 32'hFFFF_FFE0) == BASE;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        if (!in_window(a)) return 32'd0;
        case (a[4:2])
            3'd0: return {29'd0, m_irqen, m_auto, m_en};
            3'd1: return m_load;
            3'd2: return m_count;
            3'd3: return {31'd0, m_exp};
            3'd4: return m_pre;
            default: return 32'd0;
        endcase
    endfunction

    // Apply one rising edge worth of behaviour given the bus inputs of the cycle
    function automatic void model_edge(bit we, logic [31:0] a, logic [31:0] wd);
        bit          w      = we && in_window(a);
        int unsigned off    = a[4:2];
        bit          tick   = m_en && ((m_phase % (m_pre + 1)) == m_pre);
        bit          expire = tick && (m_count == 32'd0);
        logic [31:0] nc     = m_count;
        bit          ne     = m_en;
        bit          nx     = m_exp;
        if (tick) nc = (m_count != 32'd0) ? m_count - 32'd1 : (m_auto ? m_load : m_count);
        if (w && off == 2) nc = wd;
        if (w && off == 3 && wd[0]) nx = 0;
        if (expire) nx = 1;
        if (expire && !m_auto) ne = 0;
        if (m_en) m_phase = m_phase + 1;
        if (w && (off == 0 || off == 4)) m_phase = 0;
        if (w && off == 0) begin
            ne = wd[0]; m_auto = wd[1]; m_irqen = wd[2];
        end
        if (w && off == 1) m_load = wd;
        if (w && off == 4) m_pre = wd[15:0];
        m_count = nc; m_en = ne; m_exp = nx;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        mem_write = 1'b0; address = 32'd0; write_data = 32'd0;
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #2 nreset = 1'b1;
        model_reset();
    endtask

    // One bus write: drive mid-cycle, commit on the edge, return mid-next-cycle
    task automatic wr(logic [31:0] a, logic [31:0] d);
        mem_write = 1'b1; address = a; write_data = d;
        @(posedge clk);
        #2 mem_write = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic rd(string name, logic [31:0] a, logic [31:0] exp);
        address = a;
        #1 check(name, read_data, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_sel;
    } vec_t;

    vec_t vecs[$];

    task automatic add(bit we, logic [31:0] a, logic [31:0] d, logic [31:0] er, bit es);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.exp_rd = er; v.exp_sel = es;
        vecs.push_back(v);
    endtask

    initial begin
        do_reset();

        // Reset values, decode, write/readback, masking and unmapped offsets
        add(0, BASE + 32'h00, 32'd0, 32'd0, 1);
        add(0, BASE + 32'h04, 32'd0, 32'd0, 1);
        add(0, BASE + 32'h08, 32'd0, 32'd0, 1);
        add(0, BASE + 32'h0C, 32'd0, 32'd0, 1);
        add(0, BASE + 32'h10, 32'd0, 32'd0, 1);
        add(0, BASE + 32'h14, 32'd0, 32'd0, 1);
        add(0, BASE + 32'h18, 32'd0, 32'd0, 1);
        add(0, BASE + 32'h1C, 32'd0, 32'd0, 1);
        add(0, 32'h0000_0010, 32'd0, 32'd0, 0);
        add(1, A_LOAD, 32'hDEAD_BEEF, 32'd0, 1);
        add(0, BASE + 32'h07, 32'd0, 32'hDEAD_BEEF, 1);
        add(1, A_PRE, 32'hFFFF_1234, 32'd0, 1);
        add(0, A_PRE, 32'd0, 32'h0000_1234, 1);
        add(1, A_CTRL, 32'hFFFF_FFF6, 32'd0, 1);
        add(0, A_CTRL, 32'd0, 32'h0000_0006, 1);
        add(1, A_CNT, 32'h0000_0055, 32'd0, 1);
        add(0, A_CNT, 32'd0, 32'h0000_0055, 1);
        add(1, BASE + 32'h18, 32'hFFFF_FFFF, 32'd0, 1);
        add(0, BASE + 32'h18, 32'd0, 32'd0, 1);
        add(0, A_CTRL, 32'd0, 32'h0000_0006, 1);
        add(0, A_LOAD, 32'd0, 32'hDEAD_BEEF, 1);
        add(1, A_STAT, 32'h0000_0001, 32'd0, 1);
        add(0, A_STAT, 32'd0, 32'd0, 1);
        add(1, 32'h0000_0008, 32'd0, 32'd0, 0);
        add(0, A_CNT, 32'd0, 32'h0000_0055, 1);
        add(0, BASE + 32'h20, 32'd0, 32'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            mem_write = vecs[i].we; address = vecs[i].addr; write_data = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), read_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_select", i), {31'd0, select}, {31'd0, vecs[i].exp_sel});
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'd0);
            @(posedge clk);
            #2 mem_write = 1'b0;
        end

        // Auto-reload: LOAD=3, PRESCALE=1, CTRL=EN|AUTO|IRQ_EN
        do_reset();
        wr(A_LOAD, 32'd3); wr(A_PRE, 32'd1); wr(A_CTRL, 32'd7);
        rd("ar_c0_status", A_STAT, 32'd0);
        cyc(); rd("ar_c1_status", A_STAT, 32'd0);
        check("ar_c1_irq", {31'd0, irq}, 32'd0);
        cyc(); rd("ar_c2_status", A_STAT, 32'd1);
        check("ar_c2_irq", {31'd0, irq}, 32'd1);
        rd("ar_c2_count", A_CNT, 32'd3);
        cyc(); rd("ar_c3_count", A_CNT, 32'd3);
        cyc(); rd("ar_c4_count", A_CNT, 32'd2);
        wr(A_STAT, 32'd1);
        rd("ar_c5_status", A_STAT, 32'd0);
        check("ar_c5_irq", {31'd0, irq}, 32'd0);
        rd("ar_c5_count", A_CNT, 32'd2);
        cyc(); rd("ar_c6_count", A_CNT, 32'd1);
        cyc(); cyc(); rd("ar_c8_count", A_CNT, 32'd0);
        cyc(); rd("ar_c9_status", A_STAT, 32'd0);
        cyc(); rd("ar_c10_status", A_STAT, 32'd1);
        check("ar_c10_irq", {31'd0, irq}, 32'd1);
        rd("ar_c10_count", A_CNT, 32'd3);

        // One-shot: COUNT=2, PRESCALE=0, CTRL=EN
        do_reset();
        wr(A_CNT, 32'd2); wr(A_PRE, 32'd0); wr(A_CTRL, 32'd1);
        cyc(); cyc();
        rd("os_c2_status", A_STAT, 32'd0);
        rd("os_c2_count", A_CNT, 32'd0);
        cyc();
        rd("os_c3_status", A_STAT, 32'd1);
        rd("os_c3_ctrl", A_CTRL, 32'd0);
        rd("os_c3_count", A_CNT, 32'd0);
        check("os_c3_irq", {31'd0, irq}, 32'd0);
        cyc(); cyc();
        rd("os_c5_count", A_CNT, 32'd0);
        check("os_c5_irq", {31'd0, irq}, 32'd0);

        // Write-1-clear of STATUS in the expiry cycle loses to the set
        do_reset();
        wr(A_PRE, 32'd0); wr(A_CNT, 32'd1); wr(A_CTRL, 32'd5);
        cyc();
        wr(A_STAT, 32'd1);
        rd("w1c_race_status", A_STAT, 32'd1);
        check("w1c_race_irq", {31'd0, irq}, 32'd1);
        wr(A_STAT, 32'd1);
        rd("w1c_next_status", A_STAT, 32'd0);
        check("w1c_next_irq", {31'd0, irq}, 32'd0);

        // COUNT write coincident with a tick wins; unmapped write changes nothing
        do_reset();
        wr(A_PRE, 32'd3); wr(A_CNT, 32'h200); wr(A_CTRL, 32'd1);
        cyc(); cyc(); cyc();
        wr(A_CNT, 32'h100);
        rd("cw_c4_count", A_CNT, 32'h100);
        wr(BASE + 32'h18, 32'hFFFF_FFFF);
        rd("um_ctrl", A_CTRL, 32'd1);
        rd("um_load", A_LOAD, 32'd0);
        rd("um_pre", A_PRE, 32'd3);
        rd("um_status", A_STAT, 32'd0);
        rd("cw_c5_count", A_CNT, 32'h100);
        cyc(); cyc();
        rd("cw_c7_count", A_CNT, 32'h100);
        cyc();
        rd("cw_c8_count", A_CNT, 32'h0FF);

        // Reset mid-count clears everything and nothing resumes
        do_reset();
        wr(A_PRE, 32'd0); wr(A_CNT, 32'd5); wr(A_CTRL, 32'd1);
        cyc();
        rd("rm_before", A_CNT, 32'd4);
        nreset = 1'b0;
        #1;
        rd("rm_during_count", A_CNT, 32'd0);
        rd("rm_during_ctrl", A_CTRL, 32'd0);
        @(posedge clk);
        #2 nreset = 1'b1;
        model_reset();
        rd("rm_after_count", A_CNT, 32'd0);
        rd("rm_after_pre", A_PRE, 32'd0);
        cyc(); cyc(); cyc();
        rd("rm_idle_status", A_STAT, 32'd0);
        rd("rm_idle_ctrl", A_CTRL, 32'd0);
        wr(A_CNT, 32'd5);
        cyc(); cyc();
        rd("rm_no_tick", A_CNT, 32'd5);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int unsigned off = $urandom_range(0, 7);
            int unsigned lsb = $urandom_range(0, 3);
            logic [31:0] r   = $urandom;
            logic [31:0] a;
            logic [31:0] d;
            bit          we  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) a = r & 32'h0000_FFFF;
            else a = BASE | (off << 2) | lsb;
            case (a[4:2])
                3'd1:    d = $urandom_range(0, 6);
                3'd2:    d = $urandom_range(0, 10);
                3'd4:    d = (r & 32'hFFFF_0000) | $urandom_range(0, 3);
                default: d = $urandom;
            endcase
            mem_write = we; address = a; write_data = d;
            #1;
            check("rnd_rdata", read_data, model_read(a));
            check("rnd_select", {31'd0, select}, {31'd0, in_window(a)});
            check("rnd_irq", {31'd0, irq}, {31'd0, (m_exp && m_irqen)});
            @(posedge clk);
            model_edge(we, a, d);
            #2 mem_write = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
